pc_seq_unit: RTL and testbench

Next-generation program counter for the MIPS core, replacing the single-mode PC register. The PC width and reset/exception vectors are parametrised. The unit supports an optional architectural branch delay slot through a pending-redirect state machine, a pipeline stall, exception entry with EPC/BD capture, ERET return, and detection of misaligned jump-register targets. It sits at the head of the fetch stage and drives the instruction-memory address.

---
 rtl/mips_pc_defs_pkg.sv | 21 ++
 rtl/pc_target_calc.sv | 45 ++++
 rtl/pc_seq_unit.sv | 129 ++++++++++++
 tb/tb_pc_seq_unit.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pc_defs_pkg.sv
// Shared definitions for the MIPS program-counter unit.
// Holds the branch-control codes, the sequencer states and the default vectors.
package mips_pc_defs;

    typedef enum logic [2:0] {
        BR_SEQ  = 3'b000,
        BR_COND = 3'b001,
        BR_J    = 3'b011,
        BR_JR   = 3'b111,
        BR_ERET = 3'b100
    } br_code_e;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PENDING = 1'b1
    } pc_state_e;

    localparam logic [31:0] DEF_RESET_VEC = 32'h0000_3000;
    localparam logic [31:0] DEF_EXC_VEC   = 32'h0000_4180;

endpackage

// File: rtl/pc_target_calc.sv
// Combinational next-PC and redirect-target computation for the PC unit.
// It also classifies the current Branch code as a redirect or as a misaligned jr.
module pc_target_calc import mips_pc_defs::*; #(
    parameter int unsigned ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] pc,
    input  logic [2:0]        branch,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] br_offset,
    input  logic [25:0]       jump_target,
    input  logic [ADDR_W-1:0] jr_target,
    output logic [ADDR_W-1:0] npc,
    output logic [ADDR_W-1:0] target,
    output logic              redirect,
    output logic              misaligned
);

    assign npc        = pc + ADDR_W'(4);
    assign misaligned = (branch == BR_JR) && (jr_target[1:0] != 2'b00);

    always_comb begin
        target   = npc;
        redirect = 1'b0;
        case (branch)
            BR_COND: begin
                target   = npc + (br_offset << 2);
                redirect = br_taken;
            end
            BR_J: begin
                // The j target keeps the upper region bits of the delay-slot address.
                target   = {npc[ADDR_W-1:28], jump_target, 2'b00};
                redirect = 1'b1;
            end
            BR_JR: begin
                target   = jr_target;
                redirect = !misaligned;
            end
            default: begin
                target   = npc;
                redirect = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/pc_seq_unit.sv
// Program counter with optional branch delay slot, stall, exception entry and ERET.
// Misaligned jr targets are raised as address-error exceptions.
module pc_seq_unit import mips_pc_defs::*; #(
    parameter int unsigned       ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] RESET_VEC  = ADDR_W'(DEF_RESET_VEC),
    parameter logic [ADDR_W-1:0] EXC_VEC    = ADDR_W'(DEF_EXC_VEC),
    parameter bit                DELAY_SLOT = 1'b1
) (
    input  logic              Clk,
    input  logic              PcReSet,
    input  logic              Stall,
    input  logic [2:0]        Branch,
    input  logic              BrTaken,
    input  logic [ADDR_W-1:0] BrOffset,
    input  logic [25:0]       JumpTarget,
    input  logic [ADDR_W-1:0] JrTarget,
    input  logic              Exc,
    output logic [ADDR_W-1:0] PC,
    output logic [ADDR_W-1:0] NPC,
    output logic [ADDR_W-1:0] EPC,
    output logic              BD,
    output logic              AdrErr,
    output logic [ADDR_W-1:0] BadVAddr
);

    pc_state_e         state_reg, state_next;
    logic [ADDR_W-1:0] pc_reg, pc_next;
    logic [ADDR_W-1:0] pend_reg, pend_next;
    logic [ADDR_W-1:0] epc_reg, epc_next;
    logic [ADDR_W-1:0] bad_reg, bad_next;
    logic              bd_reg, bd_next;
    logic              adr_reg, adr_next;

    logic [ADDR_W-1:0] npc;
    logic [ADDR_W-1:0] target;
    logic              redirect;
    logic              misaligned;
    logic              mis_active;

    pc_target_calc #(.ADDR_W(ADDR_W)) u_calc (
        .pc          (pc_reg),
        .branch      (Branch),
        .br_taken    (BrTaken),
        .br_offset   (BrOffset),
        .jump_target (JumpTarget),
        .jr_target   (JrTarget),
        .npc         (npc),
        .target      (target),
        .redirect    (redirect),
        .misaligned  (misaligned)
    );

    // Branch inputs are ignored in the delay slot, so a misaligned jr there is too.
    assign mis_active = misaligned && (state_reg == ST_IDLE);

    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        pend_next  = pend_reg;
        epc_next   = epc_reg;
        bd_next    = bd_reg;
        bad_next   = bad_reg;
        adr_next   = 1'b0;
        if (!Stall) begin
            if (Exc || mis_active) begin
                pc_next    = EXC_VEC;
                state_next = ST_IDLE;
                pend_next  = '0;
                // In the slot, EPC must point back at the branch so it re-executes.
                if (state_reg == ST_PENDING) begin
                    epc_next = pc_reg - ADDR_W'(4);
                    bd_next  = 1'b1;
                end else begin
                    epc_next = pc_reg;
                    bd_next  = 1'b0;
                end
                if (mis_active) begin
                    bad_next = JrTarget;
                    adr_next = 1'b1;
                end
            end else if (state_reg == ST_PENDING) begin
                pc_next    = pend_reg;
                pend_next  = '0;
                state_next = ST_IDLE;
            end else if (Branch == BR_ERET) begin
                pc_next = epc_reg;
                bd_next = 1'b0;
            end else if (redirect) begin
                if (DELAY_SLOT) begin
                    pend_next  = target;
                    pc_next    = npc;
                    state_next = ST_PENDING;
                end else begin
                    pc_next = target;
                end
            end else begin
                pc_next = npc;
            end
        end
    end

    always_ff @(posedge Clk or posedge PcReSet) begin
        if (PcReSet) begin
            state_reg <= ST_IDLE;
            pc_reg    <= RESET_VEC;
            pend_reg  <= '0;
            epc_reg   <= '0;
            bd_reg    <= 1'b0;
            bad_reg   <= '0;
            adr_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            pend_reg  <= pend_next;
            epc_reg   <= epc_next;
            bd_reg    <= bd_next;
            bad_reg   <= bad_next;
            adr_reg   <= adr_next;
        end
    end

    assign PC       = pc_reg;
    assign NPC      = npc;
    assign EPC      = epc_reg;
    assign BD       = bd_reg;
    assign AdrErr   = adr_reg;
    assign BadVAddr = bad_reg;

endmodule

// File: tb/tb_pc_seq_unit.sv
// Bench for pc_seq_unit: one instance without and one with a delay slot, same stimulus,
// directed scenarios with fixed expectations followed by random traffic against a reference model.
module tb_pc_seq_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0;
    logic [2:0]  branch = 3'b000;
    logic        br_taken = 1'b0;
    logic [31:0] br_offset = '0;
    logic [25:0] jump_target = '0;
    logic [31:0] jr_target = '0;
    logic        exc = 1'b0;

    logic [31:0] pc0, npc0, epc0, bad0, pc1, npc1, epc1, bad1;
    logic        bd0, adr0, bd1, adr1;

    int checks = 0;
    int errors = 0;

    // Reference state per instance: index 0 = immediate redirect, 1 = delay slot.
    logic [31:0] m_pc [2];
    logic [31:0] m_epc [2];
    logic [31:0] m_bad [2];
    logic [31:0] m_tgt [2];
    logic        m_bd [2];
    logic        m_adr [2];
    logic        m_pend [2];

    always #5 clk = ~clk;

    pc_seq_unit #(.ADDR_W(32), .DELAY_SLOT(1'b0)) dut0 (
        .Clk(clk), .PcReSet(rst), .Stall(stall), .Branch(branch), .BrTaken(br_taken),
        .BrOffset(br_offset), .JumpTarget(jump_target), .JrTarget(jr_target), .Exc(exc),
        .PC(pc0), .NPC(npc0), .EPC(epc0), .BD(bd0), .AdrErr(adr0), .BadVAddr(bad0)
    );

    pc_seq_unit #(.ADDR_W(32), .DELAY_SLOT(1'b1)) dut1 (
        .Clk(clk), .PcReSet(rst), .Stall(stall), .Branch(branch), .BrTaken(br_taken),
        .BrOffset(br_offset), .JumpTarget(jump_target), .JrTarget(jr_target), .Exc(exc),
        .PC(pc1), .NPC(npc1), .EPC(epc1), .BD(bd1), .AdrErr(adr1), .BadVAddr(bad1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_pc[k] = 32'h3000; m_epc[k] = '0; m_bad[k] = '0; m_tgt[k] = '0;
            m_bd[k] = 1'b0; m_adr[k] = 1'b0; m_pend[k] = 1'b0;
        end
    endtask

    // One clock edge of the architectural rules, evaluated on the inputs present at the edge.
    task automatic model_step(input int k);
        logic [31:0] seq_pc, tgt;
        logic        mis, redir;
        m_adr[k] = 1'b0;
        if (stall) return;
        seq_pc = m_pc[k] + 32'd4;
        mis    = !m_pend[k] && branch == 3'b111 && jr_target[1:0] != 2'b00;
        redir  = 1'b0;
        tgt    = seq_pc;
        if (branch == 3'b001 && br_taken) begin redir = 1'b1; tgt = seq_pc + (br_offset * 4); end
        if (branch == 3'b011) begin redir = 1'b1; tgt = {seq_pc[31:28], jump_target, 2'b00}; end
        if (branch == 3'b111 && !mis) begin redir = 1'b1; tgt = jr_target; end
        if (exc || mis) begin
            m_epc[k]  = m_pend[k] ? m_pc[k] - 32'd4 : m_pc[k];
            m_bd[k]   = m_pend[k];
            m_pc[k]   = 32'h4180;
            m_pend[k] = 1'b0;
            if (mis) begin m_adr[k] = 1'b1; m_bad[k] = jr_target; end
        end else if (m_pend[k]) begin
            m_pc[k]   = m_tgt[k];
            m_pend[k] = 1'b0;
        end else if (branch == 3'b100) begin
            m_pc[k] = m_epc[k];
            m_bd[k] = 1'b0;
        end else if (redir && k == 1) begin
            m_tgt[k]  = tgt;
            m_pend[k] = 1'b1;
            m_pc[k]   = seq_pc;
        end else if (redir) begin
            m_pc[k] = tgt;
        end else begin
            m_pc[k] = seq_pc;
        end
    endtask

    task automatic check_model();
        chk("m0_pc", pc0, m_pc[0]);   chk("m1_pc", pc1, m_pc[1]);
        chk("m0_npc", npc0, m_pc[0] + 32'd4); chk("m1_npc", npc1, m_pc[1] + 32'd4);
        chk("m0_epc", epc0, m_epc[0]); chk("m1_epc", epc1, m_epc[1]);
        chk("m0_bd", {31'd0, bd0}, {31'd0, m_bd[0]});
        chk("m1_bd", {31'd0, bd1}, {31'd0, m_bd[1]});
        chk("m0_adr", {31'd0, adr0}, {31'd0, m_adr[0]});
        chk("m1_adr", {31'd0, adr1}, {31'd0, m_adr[1]});
        chk("m0_bad", bad0, m_bad[0]); chk("m1_bad", bad1, m_bad[1]);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
        check_model();
        $display("t=%0t br=%b tk=%b exc=%b stall=%b pc0=%h pc1=%h epc1=%h bd1=%b adr0=%b",
                 $time, branch, br_taken, exc, stall, pc0, pc1, epc1, bd1, adr0);
    endtask

    task automatic idle_inputs();
        stall = 1'b0; branch = 3'b000; br_taken = 1'b0; exc = 1'b0;
    endtask

    // Reset is asserted between edges so its asynchronous effect is visible immediately.
    task automatic do_reset();
        idle_inputs();
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check_model();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        model_reset();
        @(negedge clk);

        // Reset and free-running fetch
        do_reset();
        chk("t1_reset_pc", pc1, 32'h3000);
        chk("t1_reset_epc", epc1, 32'h0);
        tick(); chk("t1_pc1", pc1, 32'h3004);
        tick(); chk("t1_pc2", pc1, 32'h3008);
        tick(); chk("t1_pc3", pc1, 32'h300C);

        // Taken conditional branch with delay slot
        do_reset();
        tick(); tick();
        branch = 3'b001; br_taken = 1'b1; br_offset = 32'd4;
        tick(); chk("t2_slot", pc1, 32'h300C);
        idle_inputs();
        tick(); chk("t2_target", pc1, 32'h301C);

        // Untaken conditional branch
        do_reset();
        tick(); tick();
        branch = 3'b001; br_taken = 1'b0; br_offset = 32'd4;
        tick(); chk("t2_nt1", pc1, 32'h300C);
        idle_inputs();
        tick(); chk("t2_nt2", pc1, 32'h3010);

        // Immediate j, then misaligned jr
        do_reset();
        branch = 3'b011; jump_target = 26'h0000C40;
        tick(); chk("t3_j", pc0, 32'h3100);
        branch = 3'b111; jr_target = 32'h3202;
        tick();
        chk("t3_exc_pc", pc0, 32'h4180);
        chk("t3_adrerr", {31'd0, adr0}, 32'd1);
        chk("t3_badva", bad0, 32'h3202);
        chk("t3_epc", epc0, 32'h3100);
        idle_inputs();
        tick(); chk("t3_adr_pulse", {31'd0, adr0}, 32'd0);

        // Exception in the delay slot, then ERET
        do_reset();
        repeat (4) tick();
        branch = 3'b111; jr_target = 32'h3400;
        tick(); chk("t4_slot", pc1, 32'h3014);
        idle_inputs(); exc = 1'b1;
        tick();
        chk("t4_exc_pc", pc1, 32'h4180);
        chk("t4_epc", epc1, 32'h3010);
        chk("t4_bd", {31'd0, bd1}, 32'd1);
        idle_inputs(); branch = 3'b100;
        tick();
        chk("t4_eret_pc", pc1, 32'h3010);
        chk("t4_eret_bd", {31'd0, bd1}, 32'd0);

        // Stall while pending
        do_reset();
        repeat (4) tick();
        branch = 3'b111; jr_target = 32'h3400;
        tick();
        idle_inputs(); stall = 1'b1; exc = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(); chk("t5_hold", pc1, 32'h3014);
        end
        idle_inputs();
        tick(); chk("t5_release", pc1, 32'h3400);

        // Asynchronous reset mid-redirect
        do_reset();
        repeat (4) tick();
        branch = 3'b111; jr_target = 32'h3400;
        tick();
        do_reset();
        chk("t6_async_pc", pc1, 32'h3000);
        tick(); chk("t6_seq1", pc1, 32'h3004);
        tick(); chk("t6_seq2", pc1, 32'h3008);

        // Random traffic against the reference model
        do_reset();
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 7))
                0, 1:    branch = 3'b000;
                2:       branch = 3'b001;
                3:       branch = 3'b011;
                4:       branch = 3'b111;
                5:       branch = 3'b100;
                6:       branch = 3'b010;
                default: branch = 3'b000;
            endcase
            br_taken    = 1'($urandom_range(0, 1));
            br_offset   = 32'($signed($urandom_range(0, 32)) - 16);
            jump_target = 26'($urandom);
            jr_target   = {16'h0, 14'($urandom), ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00};
            exc         = ($urandom_range(0, 15) == 0);
            stall       = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 99) == 0) do_reset();
            else tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
